// File: rtl/result_display_pkg.sv
// rtl/result_display_pkg.sv - shared types, sizes and segment codes for the result display
package result_display_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CONVERT = 1'b1
    } state_e;

    localparam int NUM_DIGITS = 6;
    localparam int BCD_W      = 20;
    localparam int DATA_W     = 17;

    // Active-low, bit order gfedcba
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] r;
        r = bcd;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/result_display_bcd_to_seg.sv
// rtl/result_display_bcd_to_seg.sv - one BCD digit to active-low seven-segment code
import result_display_pkg::*;

module bcd_to_seg (
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/result_display.sv
// rtl/result_display.sv - signed divider result to scanned six-digit seven-segment display
import result_display_pkg::*;

module result_display #(
    parameter int REFRESH_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_output,
    input  logic [16:0] final_output,
    input  logic        mode,
    output logic        busy,
    output logic        overrun,
    output logic [5:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] mag_q, mag_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic              cap_sign_q, cap_sign_d;
    logic              cap_mode_q, cap_mode_d;
    logic [BCD_W-1:0]  disp_bcd_q, disp_bcd_d;
    logic              disp_sign_q, disp_sign_d;
    logic              disp_mode_q, disp_mode_d;
    logic              disp_valid_q, disp_valid_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic [RW-1:0]     refresh_q, refresh_d;
    logic [2:0]        digit_idx_q, digit_idx_d;

    logic [BCD_W-1:0]  bcd_adj;
    logic [3:0]        cur_nibble;
    logic              lead_zero;
    logic [6:0]        dec_seg;

    always_comb begin
        state_d      = state_q;
        mag_d        = mag_q;
        bcd_d        = bcd_q;
        bit_cnt_d    = bit_cnt_q;
        cap_sign_d   = cap_sign_q;
        cap_mode_d   = cap_mode_q;
        disp_bcd_d   = disp_bcd_q;
        disp_sign_d  = disp_sign_q;
        disp_mode_d  = disp_mode_q;
        disp_valid_d = disp_valid_q;
        busy_d       = busy_q;
        overrun_d    = 1'b0;
        bcd_adj      = dabble_adjust(bcd_q);

        case (state_q)
            ST_IDLE: begin
                if (valid_output) begin
                    cap_sign_d = final_output[16];
                    mag_d      = final_output[16] ? (~final_output + 17'd1) : final_output;
                    cap_mode_d = mode;
                    bcd_d      = '0;
                    bit_cnt_d  = '0;
                    busy_d     = 1'b1;
                    state_d    = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                // A strobe here, including on the final conversion cycle, is dropped
                overrun_d = valid_output;
                bcd_d     = {bcd_adj[BCD_W-2:0], mag_q[DATA_W-1]};
                mag_d     = {mag_q[DATA_W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'(DATA_W - 1)) begin
                    disp_bcd_d   = bcd_d;
                    disp_sign_d  = cap_sign_q;
                    disp_mode_d  = cap_mode_q;
                    disp_valid_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        refresh_d   = refresh_q + 1'b1;
        digit_idx_d = digit_idx_q;
        if (refresh_q == RW'(REFRESH_CYCLES - 1)) begin
            refresh_d   = '0;
            digit_idx_d = (digit_idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : digit_idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mag_q        <= '0;
            bcd_q        <= '0;
            bit_cnt_q    <= '0;
            cap_sign_q   <= 1'b0;
            cap_mode_q   <= 1'b0;
            disp_bcd_q   <= '0;
            disp_sign_q  <= 1'b0;
            disp_mode_q  <= 1'b0;
            disp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            refresh_q    <= '0;
            digit_idx_q  <= '0;
        end else begin
            state_q      <= state_d;
            mag_q        <= mag_d;
            bcd_q        <= bcd_d;
            bit_cnt_q    <= bit_cnt_d;
            cap_sign_q   <= cap_sign_d;
            cap_mode_q   <= cap_mode_d;
            disp_bcd_q   <= disp_bcd_d;
            disp_sign_q  <= disp_sign_d;
            disp_mode_q  <= disp_mode_d;
            disp_valid_q <= disp_valid_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            refresh_q    <= refresh_d;
            digit_idx_q  <= digit_idx_d;
        end
    end

    // A digit above 0 is blank when it and every digit to its left are zero
    always_comb begin
        cur_nibble = 4'd0;
        lead_zero  = 1'b1;
        case (digit_idx_q)
            3'd0: begin cur_nibble = disp_bcd_q[3:0];   lead_zero = 1'b0; end
            3'd1: begin cur_nibble = disp_bcd_q[7:4];   lead_zero = (disp_bcd_q[19:4]  == '0); end
            3'd2: begin cur_nibble = disp_bcd_q[11:8];  lead_zero = (disp_bcd_q[19:8]  == '0); end
            3'd3: begin cur_nibble = disp_bcd_q[15:12]; lead_zero = (disp_bcd_q[19:12] == '0); end
            3'd4: begin cur_nibble = disp_bcd_q[19:16]; lead_zero = (disp_bcd_q[19:16] == '0); end
            default: begin cur_nibble = 4'd0; lead_zero = 1'b1; end
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .digit (cur_nibble),
        .blank (!disp_valid_q || lead_zero),
        .seg   (dec_seg)
    );

    assign an      = ~(6'b000001 << digit_idx_q);
    assign seg     = (digit_idx_q == 3'd5) ? (disp_sign_q ? SEG_MINUS : SEG_BLANK) : dec_seg;
    assign dp      = !((digit_idx_q == 3'd5) && disp_mode_q);
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_result_display.sv
// tb/tb_result_display.sv - randomized self-checking bench for result_display
module tb_result_display;

    localparam int REFRESH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_output;
    logic [16:0] final_output;
    logic        mode;
    logic        busy;
    logic        overrun;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int errors = 0;

    bit          m_valid;
    int          m_val;
    bit          m_mode;
    logic [6:0]  seg_tbl [10];

    result_display #(.REFRESH_CYCLES(REFRESH)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_output (valid_output),
        .final_output (final_output),
        .mode         (mode),
        .busy         (busy),
        .overrun      (overrun),
        .an           (an),
        .seg          (seg),
        .dp           (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int an_index(input logic [5:0] a);
        for (int i = 0; i < 6; i++) begin
            if (a[i] == 1'b0) return i;
        end
        return 0;
    endfunction

    // Expected segments for a digit position from the plain decimal value
    function automatic logic [6:0] exp_seg(input int pos, input bit v, input int val);
        int mag;
        int p10;
        mag = (val < 0) ? -val : val;
        p10 = 1;
        for (int i = 0; i < pos; i++) p10 = p10 * 10;
        if (!v) return 7'h7F;
        if (pos == 5) return (val < 0) ? 7'h3F : 7'h7F;
        if (pos > 0 && mag < p10) return 7'h7F;
        return seg_tbl[(mag / p10) % 10];
    endfunction

    task automatic check_outputs(input string tag, input bit v, input int val, input bit md);
        int idx;
        idx = an_index(an);
        check({tag, "_an_onehot"}, $countones(~an), 1);
        check({tag, "_seg"}, seg, exp_seg(idx, v, val));
        check({tag, "_dp"}, dp, !(idx == 5 && md));
    endtask

    task automatic check_display();
        for (int c = 0; c < 6 * REFRESH; c++) begin
            @(negedge clk);
            check_outputs("scan", m_valid, m_val, m_mode);
        end
    endtask

    task automatic run_conv(input int val, input bit md, input int extra_at, input int extra_val);
        @(negedge clk);
        valid_output = 1'b1;
        final_output = val[16:0];
        mode         = md;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            valid_output = 1'b0;
            if (extra_at == k) begin
                valid_output = 1'b1;
                final_output = extra_val[16:0];
                mode         = ~md;
            end
            check("busy", busy, 32'(k <= 17));
            check("overrun", overrun, 32'(extra_at != 0 && (k - 1) == extra_at));
            if (k - 1 < 17) check_outputs("hold", m_valid, m_val, m_mode);
            else            check_outputs("update", 1'b1, val, md);
        end
        valid_output = 1'b0;
        m_valid = 1'b1;
        m_val   = val;
        m_mode  = md;
        check_display();
    endtask

    initial begin
        logic signed [16:0] rs;
        int extra;

        seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        m_valid = 1'b0;
        m_val   = 0;
        m_mode  = 1'b0;
        reset        = 1'b1;
        valid_output = 1'b0;
        final_output = '0;
        mode         = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_an", an, 6'b111110);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1);

        reset = 1'b0;
        for (int t = 0; t < 30; t++) begin
            check("scan_an", an, 32'(~(6'b000001 << ((t / REFRESH) % 6)) & 6'h3F));
            check("blank_seg", seg, 7'h7F);
            @(negedge clk);
        end

        run_conv(26, 1'b0, 0, 0);
        run_conv(2, 1'b1, 0, 0);
        run_conv(-65536, 1'b0, 0, 0);
        run_conv(0, 1'b1, 0, 0);
        run_conv(123, 1'b0, 5, 999);
        run_conv(-4321, 1'b1, 17, 77);
        run_conv(65535, 1'b0, 1, -5);
        run_conv(-1, 1'b1, 0, 0);
        run_conv(10000, 1'b0, 0, 0);

        for (int n = 0; n < 12; n++) begin
            rs    = 17'($urandom);
            extra = ($urandom % 3 == 0) ? int'($urandom_range(1, 17)) : 0;
            run_conv(int'(rs), 1'($urandom), extra, int'($urandom_range(0, 65535)));
        end

        // Reset sampled on the ninth conversion cycle aborts and blanks the display
        @(negedge clk);
        valid_output = 1'b1;
        final_output = 17'd54321;
        mode         = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            valid_output = 1'b0;
            if (k == 9) reset = 1'b1;
        end
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_an", an, 6'b111110);
        check("abort_seg", seg, 7'h7F);
        check("abort_dp", dp, 1);
        reset   = 1'b0;
        m_valid = 1'b0;
        m_val   = 0;
        m_mode  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("abort_idle", busy, 0);
        end
        check_display();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
